mem_sequencer: RTL

Memory-side controller between the micro-op core and an 8-bit external bus, shared by the core's data port and the fetch unit. It latches the core's data requests (MAR prepare, start, width, command, transaction id) and arbitrates them against instruction-fetch word reads. It splits 16-bit accesses into two little-endian byte cycles with wait-state handshake. It returns read data tagged with the transaction id, and stalls the core through `hold` while a data access is outstanding.

---
 rtl/mem_sequencer_if.sv | 39 +++
 rtl/mem_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer_if.sv
// Core/fetch/external-bus signal bundle for mem_sequencer.
// master: core, fetch unit and bus model side; slave: the sequencer.
interface mem_sequencer_if;
  logic [15:0] rq_addr;
  logic [15:0] rq_data;
  logic        rq_prepare_addr;
  logic        rq_start;
  logic        rq_width;
  logic        rq_cmd;
  logic        rq_t_id;
  logic        fe_req;
  logic [15:0] fe_addr;
  logic [7:0]  bus_din;
  logic        bus_ready;
  logic [15:0] data_out;
  logic        data_wr;
  logic        data_t_wr;
  logic [15:0] fe_data;
  logic        fe_ack;
  logic        hold;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rd;
  logic        bus_wr;

  modport master (
    output rq_addr, rq_data, rq_prepare_addr, rq_start, rq_width, rq_cmd, rq_t_id,
    output fe_req, fe_addr, bus_din, bus_ready,
    input  data_out, data_wr, data_t_wr, fe_data, fe_ack, hold,
    input  bus_addr, bus_dout, bus_rd, bus_wr
  );

  modport slave (
    input  rq_addr, rq_data, rq_prepare_addr, rq_start, rq_width, rq_cmd, rq_t_id,
    input  fe_req, fe_addr, bus_din, bus_ready,
    output data_out, data_wr, data_t_wr, fe_data, fe_ack, hold,
    output bus_addr, bus_dout, bus_rd, bus_wr
  );
endinterface

// File: rtl/mem_sequencer.sv
// Memory sequencer: arbitrates core data requests against fetch word reads
// and splits them into little-endian byte cycles on an 8-bit bus.
module mem_sequencer (
  input  logic            clk,
  input  logic            a_rst,
  mem_sequencer_if.slave  mif
);

  typedef enum logic [2:0] {IDLE, D_LO, D_HI, F_LO, F_HI} state_e;

  state_e      state_q;
  logic [15:0] mar_q;
  logic        pv_q, pcmd_q, pwid_q, ptid_q;
  logic [15:0] pdata_q, paddr_q;
  logic        cmd_q, wid_q, tid_q;
  logic [15:0] wdata_q, addr_q;
  logic [7:0]  lo_q;
  logic [15:0] data_out_q, fe_data_q, bus_addr_q;
  logic        data_wr_q, data_t_wr_q, fe_ack_q, bus_rd_q, bus_wr_q;
  logic [7:0]  bus_dout_q;

  logic        hold;
  logic        req_fire;
  logic [15:0] req_addr;
  logic        sel_v, sel_cmd, sel_wid, sel_tid;
  logic [15:0] sel_data, sel_addr;
  logic [15:0] addr_inc;

  assign hold     = pv_q | (state_q == D_LO) | (state_q == D_HI);
  assign req_fire = mif.rq_start & ~hold;
  assign req_addr = mif.rq_prepare_addr ? mif.rq_addr : mar_q;
  assign addr_inc = addr_q + 16'd1;

  // In IDLE a pending request has priority; otherwise a live request bypasses
  // the pending register and is granted on the edge it is sampled.
  always_comb begin
    sel_v    = pv_q | req_fire;
    sel_cmd  = mif.rq_cmd;
    sel_wid  = mif.rq_width;
    sel_tid  = mif.rq_t_id;
    sel_data = mif.rq_data;
    sel_addr = req_addr;
    if (pv_q) begin
      sel_cmd  = pcmd_q;
      sel_wid  = pwid_q;
      sel_tid  = ptid_q;
      sel_data = pdata_q;
      sel_addr = paddr_q;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      pv_q        <= 1'b0;
      pcmd_q      <= 1'b0;
      pwid_q      <= 1'b0;
      ptid_q      <= 1'b0;
      pdata_q     <= '0;
      paddr_q     <= '0;
      cmd_q       <= 1'b0;
      wid_q       <= 1'b0;
      tid_q       <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      lo_q        <= '0;
      data_out_q  <= '0;
      data_wr_q   <= 1'b0;
      data_t_wr_q <= 1'b0;
      fe_data_q   <= '0;
      fe_ack_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
    end else begin
      data_wr_q <= 1'b0;
      fe_ack_q  <= 1'b0;
      if (mif.rq_prepare_addr) mar_q <= mif.rq_addr;
      if (req_fire && state_q != IDLE) begin
        pv_q    <= 1'b1;
        pcmd_q  <= mif.rq_cmd;
        pwid_q  <= mif.rq_width;
        ptid_q  <= mif.rq_t_id;
        pdata_q <= mif.rq_data;
        paddr_q <= req_addr;
      end
      case (state_q)
        IDLE: begin
          if (sel_v) begin
            pv_q       <= 1'b0;
            cmd_q      <= sel_cmd;
            wid_q      <= sel_wid;
            tid_q      <= sel_tid;
            wdata_q    <= sel_data;
            addr_q     <= sel_addr;
            bus_addr_q <= sel_addr;
            bus_dout_q <= sel_data[7:0];
            bus_rd_q   <= ~sel_cmd;
            bus_wr_q   <= sel_cmd;
            state_q    <= D_LO;
          end else if (mif.fe_req && !fe_ack_q) begin
            addr_q     <= mif.fe_addr;
            bus_addr_q <= mif.fe_addr;
            bus_rd_q   <= 1'b1;
            state_q    <= F_LO;
          end
        end
        D_LO: begin
          if (mif.bus_ready) begin
            lo_q <= mif.bus_din;
            if (wid_q) begin
              bus_addr_q <= addr_inc;
              bus_dout_q <= wdata_q[15:8];
              state_q    <= D_HI;
            end else begin
              bus_rd_q <= 1'b0;
              bus_wr_q <= 1'b0;
              state_q  <= IDLE;
              if (!cmd_q) begin
                data_out_q  <= {8'h00, mif.bus_din};
                data_wr_q   <= 1'b1;
                data_t_wr_q <= tid_q;
              end
            end
          end
        end
        D_HI: begin
          if (mif.bus_ready) begin
            bus_rd_q <= 1'b0;
            bus_wr_q <= 1'b0;
            state_q  <= IDLE;
            if (!cmd_q) begin
              data_out_q  <= {mif.bus_din, lo_q};
              data_wr_q   <= 1'b1;
              data_t_wr_q <= tid_q;
            end
          end
        end
        F_LO: begin
          if (mif.bus_ready) begin
            lo_q       <= mif.bus_din;
            bus_addr_q <= addr_inc;
            state_q    <= F_HI;
          end
        end
        F_HI: begin
          if (mif.bus_ready) begin
            bus_rd_q  <= 1'b0;
            fe_data_q <= {mif.bus_din, lo_q};
            fe_ack_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mif.data_out  = data_out_q;
  assign mif.data_wr   = data_wr_q;
  assign mif.data_t_wr = data_t_wr_q;
  assign mif.fe_data   = fe_data_q;
  assign mif.fe_ack    = fe_ack_q;
  assign mif.hold      = hold;
  assign mif.bus_addr  = bus_addr_q;
  assign mif.bus_dout  = bus_dout_q;
  assign mif.bus_rd    = bus_rd_q;
  assign mif.bus_wr    = bus_wr_q;

endmodule
